// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op codes, default latencies and the FSM state type.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the HI/LO result and a
// write enable that is dropped for divide-by-zero.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to
    // 0x80000000 with a zero remainder instead of overflowing.
    assign abs_a    = a[31] ? (32'd0 - a) : a;
    assign abs_b    = b[31] ? (32'd0 - b) : b;
    assign div_zero = (b == 32'd0);
    assign div_a    = (op == MDU_DIV) ? abs_a : a;
    assign div_b    = div_zero ? 32'd1 : ((op == MDU_DIV) ? abs_b : b);
    assign quo      = div_a / div_b;
    assign rem      = div_a % div_b;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        we = 1'b0;
        case (op)
            MDU_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
                we = 1'b1;
            end
            MDU_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
                we = 1'b1;
            end
            MDU_DIV: begin
                lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                hi = a[31] ? (32'd0 - rem) : rem;
                we = !div_zero;
            end
            MDU_DIVU: begin
                lo = quo;
                hi = rem;
                we = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div with a busy
// flag for hazard stalls, HI/LO moves and the mfhi/mflo read port.
//
// state | meaning
// IDLE  | accepts arith start or mthi/mtlo; HI/LO stable
// RUN   | result pending in RES_HI/RES_LO, counting down to commit
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        E_Busy,
    output logic [31:0] E_MDData
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0] hi, lo;
    logic [31:0] res_hi, res_lo;
    logic        res_we;
    logic        load_res;
    logic        commit;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_we;

    mdu_calc u_calc (
        .op (E_MDUOp),
        .a  (E_RS),
        .b  (E_RT),
        .hi (calc_hi),
        .lo (calc_lo),
        .we (calc_we)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_res  = 1'b0;
        commit    = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (E_Start && is_arith(E_MDUOp)) begin
                    state_nxt = ST_RUN;
                    load_res  = 1'b1;
                    cnt_nxt   = is_mult(E_MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else begin
                    mt_hi = (E_MDUOp == MDU_MTHI);
                    mt_lo = (E_MDUOp == MDU_MTLO);
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_we <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_res) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                res_we <= calc_we;
            end
            // Divide-by-zero leaves res_we low, so HI/LO survive the commit.
            if (commit && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (mt_hi) hi <= E_RS;
            if (mt_lo) lo <= E_RS;
        end
    end

    assign E_Busy   = (state == ST_RUN);
    assign E_MDData = (E_MDUOp == MDU_MFHI) ? hi :
                      (E_MDUOp == MDU_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: a reference model pushes expected busy/read
// values per cycle and a negedge monitor pops and compares them.
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        start;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] mddata;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_MDUOp  (op),
        .E_Start  (start),
        .E_RS     (rs),
        .E_RT     (rt),
        .E_Busy   (busy),
        .E_MDData (mddata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit running = 0;

    logic        exp_busy_q[$];
    logic [31:0] exp_data_q[$];

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pwe;
    int          m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwe = 0; m_left = 0;
    endtask

    // Behavioural model of one clock edge, using 64-bit integer arithmetic.
    task automatic model_edge(input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned up;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwe) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (s && o >= 4'd1 && o <= 4'd4) begin
            sa = $signed(a);
            sb = $signed(b);
            m_pwe = 1;
            case (o)
                4'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; end
                4'd2: begin up = longint'(a) * longint'(b); m_phi = up[63:32]; m_plo = up[31:0]; end
                4'd3: begin
                    if (b == 0) m_pwe = 0;
                    else begin p = sa / sb; m_plo = p[31:0]; p = sa % sb; m_phi = p[31:0]; end
                end
                default: begin
                    if (b == 0) m_pwe = 0;
                    else begin m_plo = a / b; m_phi = a % b; end
                end
            endcase
            m_left = (o <= 4'd2) ? 5 : 10;
        end else if (o == 4'd7) begin
            m_hi = a;
        end else if (o == 4'd8) begin
            m_lo = a;
        end
    endtask

    // One pipeline cycle: drive inputs, post expectations, advance the model.
    task automatic cyc(input logic [3:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
        op = o; start = s; rs = a; rt = b;
        exp_busy_q.push_back(m_left > 0);
        if (o == 4'd5) exp_data_q.push_back(m_hi);
        else if (o == 4'd6) exp_data_q.push_back(m_lo);
        model_edge(o, s, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic read_both();
        cyc(4'd5, 0, 0, 0);
        cyc(4'd6, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (running && !reset) begin
            if (exp_busy_q.size() == 0) check("busy_queue_underflow", 32'd1, 32'd0);
            else check("busy", {31'd0, busy}, {31'd0, exp_busy_q.pop_front()});
            if (op == 4'd5 || op == 4'd6) begin
                if (exp_data_q.size() == 0) check("data_queue_underflow", 32'd1, 32'd0);
                else check(op == 4'd5 ? "mfhi" : "mflo", mddata, exp_data_q.pop_front());
            end else begin
                check("mddata_idle_zero", mddata, 32'd0);
            end
        end
    end

    initial begin
        logic [3:0] ro;
        logic [31:0] ra, rb;
        reset = 1; op = 0; start = 0; rs = 0; rt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        running = 1;

        read_both();

        // MULT / MULTU with busy window
        cyc(MDU_MULT, 1, 32'hFFFFFFFE, 32'd3);
        repeat (5) cyc(MDU_MFHI, 0, 0, 0);
        read_both();
        cyc(MDU_MULTU, 1, 32'hFFFFFFFE, 32'd3);
        repeat (5) cyc(MDU_NONE, 0, 0, 0);
        read_both();

        // DIV / DIVU
        cyc(MDU_DIV, 1, -32'sd7, 32'd2);
        repeat (10) cyc(MDU_MFLO, 0, 0, 0);
        read_both();
        cyc(MDU_DIVU, 1, 32'd7, 32'd2);
        repeat (10) cyc(MDU_NONE, 0, 0, 0);
        read_both();

        // moves then divide by zero, then overflow divide
        cyc(MDU_MTHI, 0, 32'h12345678, 0);
        cyc(MDU_MTLO, 0, 32'h9ABCDEF0, 0);
        read_both();
        cyc(MDU_DIVU, 1, 32'd55, 32'd0);
        repeat (10) cyc(MDU_MFHI, 0, 0, 0);
        read_both();
        cyc(MDU_DIV, 1, 32'h80000000, 32'hFFFFFFFF);
        repeat (10) cyc(MDU_NONE, 0, 0, 0);
        read_both();

        // starts and moves during busy are ignored
        cyc(MDU_MULT, 1, 32'd1000, 32'hFFFFFFFF);
        cyc(MDU_NONE, 0, 0, 0);
        cyc(MDU_DIV, 1, 32'd9, 32'd4);
        cyc(MDU_MTLO, 1, 32'hDEADBEEF, 0);
        cyc(MDU_NONE, 0, 0, 0);
        cyc(MDU_NONE, 0, 0, 0);
        read_both();

        // mfhi during busy shows old HI until commit
        cyc(MDU_MTHI, 0, 32'hAA, 0);
        cyc(MDU_MULTU, 1, 32'h10000, 32'h10000);
        repeat (7) cyc(MDU_MFHI, 0, 0, 0);

        // async reset in busy cycle 3 of a DIV
        cyc(MDU_MTLO, 0, 32'h55, 0);
        cyc(MDU_DIV, 1, 32'd100, 32'd7);
        cyc(MDU_NONE, 0, 0, 0);
        cyc(MDU_NONE, 0, 0, 0);
        op = MDU_MFLO; start = 0;
        reset = 1;
        #1;
        check("busy_after_async_reset", {31'd0, busy}, 32'd0);
        check("lo_after_async_reset", mddata, 32'd0);
        model_reset();
        @(negedge clk);
        #2 reset = 0;
        @(posedge clk);
        #1;
        repeat (12) read_both();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            cyc(ro, 1'($urandom_range(0, 1)), ra, rb);
        end
        repeat (12) cyc(MDU_NONE, 0, 0, 0);
        read_both();

        running = 0;
        check("busy_queue_drained", 32'(exp_busy_q.size()), 32'd0);
        check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit: the producer of the HI/LO values the writeback register-write mux selects for its MD-data input. Accepts mult/multu/div/divu with fixed multi-cycle latency and direct HI/LO moves, asserts a busy flag for the hazard unit to stall on, and drives the mfhi/mflo read value down the pipeline toward writeback.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- E_MDUOp  input  4  operation code, encoding in mdu_pkg
- E_Start  input  1  qualifies a mult/multu/div/divu in E this cycle
- E_RS  input  32  operand A / mthi, mtlo source
- E_RT  input  32  operand B
- E_Busy  output  1  registered; high while an arithmetic op is in flight
- E_MDData  output  32  combinational: HI for mfhi, LO for mflo, else 0

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 behave as NONE.
- State: HI, LO (32b each, architectural); RES_HI, RES_LO (pending result); CNT (down-counter, width covers max(MULT_CYCLES, DIV_CYCLES)).
- FSM: IDLE, RUN. IDLE + E_Start with op 1-4 -> RUN: compute result from E_RS/E_RT into RES_HI/RES_LO, load CNT with the latency. RUN: decrement CNT; at CNT==1 commit RES_HI/RES_LO to HI/LO and -> IDLE.
- MULT: {HI,LO} = signed 64b product; MULTU unsigned.
- DIV: LO = quotient truncated toward zero, HI = remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU unsigned.
- Divide by zero (DIV or DIVU with E_RT==0): unit still goes busy for DIV_CYCLES; HI/LO unchanged at commit.
- MTHI/MTLO in IDLE: HI/LO <= E_RS at next edge, no busy. Ignored in RUN (hazard unit guarantees none arrive).
- E_Start while E_Busy: ignored, no restart. E_Start with op outside 1-4: ignored.
- E_MDData reads architectural HI/LO, never a pending result.
- Reset (any time, including mid-RUN): HI=LO=RES_HI=RES_LO=0, CNT=0, IDLE, E_Busy=0; pending result discarded.

## Timing
- Start sampled at edge t: E_Busy=1 for cycles t+1 .. t+N (N = MULT_CYCLES or DIV_CYCLES); HI/LO updated at the edge ending cycle t+N; E_Busy=0 and new values readable via mfhi/mflo from cycle t+N+1.
- Hazard unit stalls MDU ops in E when E_Start&&(op in 1-4) or E_Busy; back-to-back start accepted in the first cycle with E_Busy=0.
- MTHI/MTLO at edge t: visible on E_MDData from cycle t+1.
- E_MDData has zero-cycle latency from E_MDUOp.

## Structure
- mdu_pkg: op-code localparams (MDU_NONE..MDU_MTLO), default latency constants, op-class helper (is_arith).
- One sub-module natural: mdu_calc, purely combinational, op/A/B -> {hi, lo, write_enable} covering signed/unsigned mult/div and the div-by-zero/overflow rules; e_mdu holds FSM, counter, registers.

## Test plan
- MULT E_RS=0xFFFFFFFE, E_RT=3 -> E_Busy high 5 cycles; then mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA; MULTU same -> HI=0x2, LO=0xFFFFFFFA.
- DIV E_RS=-7, E_RT=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIVU x/0 -> busy 10 cycles, HI/LO remain 0x12345678/0x9ABCDEF0; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MULT started, E_Start re-asserted with DIV in busy cycle 2 and MTLO in cycle 3 -> both ignored, busy ends after 5 cycles, result is the MULT.
- Reset asserted asynchronously in busy cycle 3 of a DIV -> E_Busy falls immediately, HI=LO=0, no later commit.
- mfhi during busy after prior MTHI 0xAA -> E_MDData=0xAA until commit edge, new HI on the following cycle.
